// File: rtl/p_to_s_pkg.sv
// Shared definitions for the parallel-to-serial converter: default width,
// bit-counter sizing and the two-state shifter FSM encoding.
package p_to_s_pkg;

    localparam int DEFAULT_WIDTH = 6;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit counter must index 0..width-1 and never be narrower than one bit.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/p_to_s_hold.sv
// One-entry register slice holding the next parallel word while the shifter
// is busy; in_ready is registered and high exactly when the slot is empty.
module p_to_s_hold
    import p_to_s_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             full_r;
    logic             full_nxt_s;
    logic             ready_r;
    logic             wr_s;
    logic [WIDTH-1:0] data_r;

    // Next occupancy: a write fills the slot, a read empties it; both never coincide.
    always_comb begin
        wr_s = in_valid & ready_r;
        if (wr_s) begin
            full_nxt_s = 1'b1;
        end else if (out_ready) begin
            full_nxt_s = 1'b0;
        end else begin
            full_nxt_s = full_r;
        end
    end

    // Slot storage, full flag and the registered ready that mirrors emptiness.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r  <= 1'b0;
            ready_r <= 1'b0;
            data_r  <= '0;
        end else begin
            full_r  <= full_nxt_s;
            ready_r <= ~full_nxt_s;
            if (wr_s) begin
                data_r <= in_data;
            end else begin
                data_r <= data_r;
            end
        end
    end

    assign in_ready  = ready_r;
    assign out_valid = full_r;
    assign out_data  = data_r;

endmodule

// File: rtl/p_to_s.sv
// Parallel-to-serial converter: a word is shifted out one bit per accepted
// output cycle, with a holding slot so consecutive words leave no bubble.
module p_to_s
    import p_to_s_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_a,
    input  logic [WIDTH-1:0] data_a,
    output logic             ready_a,
    output logic             valid_b,
    output logic             data_b,
    output logic             last_b,
    input  logic             ready_b
);

    localparam int              CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] shift_nxt_s;
    logic [WIDTH-1:0] shift_adv_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             last_r;
    logic             in_fire_s;
    logic             out_fire_s;
    logic             last_fire_s;
    logic             hold_wr_s;
    logic             hold_rd_s;
    logic             hold_full_s;
    logic [WIDTH-1:0] hold_data_s;

    p_to_s_hold #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (hold_wr_s),
        .in_ready (ready_a),
        .in_data  (data_a),
        .out_valid(hold_full_s),
        .out_ready(hold_rd_s),
        .out_data (hold_data_s)
    );

    assign in_fire_s   = valid_a & ready_a;
    assign out_fire_s  = valid_b & ready_b;
    assign last_fire_s = out_fire_s & last_r;
    assign shift_adv_s = LSB_FIRST ? {1'b0, shift_r[WIDTH-1:1]} : {shift_r[WIDTH-2:0], 1'b0};

    // Next-state logic: load, advance, reload from the slot or bypass on the last bit.
    always_comb begin
        state_nxt_s = state_r;
        shift_nxt_s = shift_r;
        cnt_nxt_s   = cnt_r;
        hold_wr_s   = 1'b0;
        hold_rd_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_fire_s) begin
                    shift_nxt_s = data_a;
                    cnt_nxt_s   = '0;
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                // An input arriving with the last bit bypasses the empty slot.
                hold_wr_s = in_fire_s & ~last_fire_s;
                if (last_fire_s) begin
                    cnt_nxt_s = '0;
                    if (hold_full_s) begin
                        shift_nxt_s = hold_data_s;
                        hold_rd_s   = 1'b1;
                    end else if (in_fire_s) begin
                        shift_nxt_s = data_a;
                    end else begin
                        shift_nxt_s = '0;
                        state_nxt_s = IDLE;
                    end
                end else if (out_fire_s) begin
                    shift_nxt_s = shift_adv_s;
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                shift_nxt_s = '0;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // State, shifter, counter and last-bit flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            shift_r <= '0;
            cnt_r   <= '0;
            last_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            shift_r <= shift_nxt_s;
            cnt_r   <= cnt_nxt_s;
            last_r  <= (cnt_nxt_s == LAST_CNT);
        end
    end

    assign valid_b = (state_r == SHIFT);
    assign data_b  = LSB_FIRST ? shift_r[0] : shift_r[WIDTH-1];
    assign last_b  = last_r;

endmodule

// File: tb/tb_p_to_s.sv
// Directed bench for p_to_s: one LSB-first and one MSB-first instance,
// stimulus driven and outputs sampled on the falling clock edge.
module tb_p_to_s;

    logic       clk;
    logic       rst_n;
    logic       valid_a, ready_a, valid_b, data_b, last_b, ready_b;
    logic [5:0] data_a;
    logic       m_valid_a, m_ready_a, m_valid_b, m_data_b, m_last_b, m_ready_b;
    logic [5:0] m_data_a;
    int         n_checks;
    int         n_fail;

    p_to_s #(.WIDTH(6), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst_n(rst_n), .valid_a(valid_a), .data_a(data_a), .ready_a(ready_a),
        .valid_b(valid_b), .data_b(data_b), .last_b(last_b), .ready_b(ready_b)
    );

    p_to_s #(.WIDTH(6), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst_n(rst_n), .valid_a(m_valid_a), .data_a(m_data_a), .ready_a(m_ready_a),
        .valid_b(m_valid_b), .data_b(m_data_b), .last_b(m_last_b), .ready_b(m_ready_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; valid_a = 1'b0; data_a = 6'h00; ready_b = 1'b0;
        m_valid_a = 1'b0; m_data_a = 6'h00; m_ready_b = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ready_a, valid_b, data_b, last_b} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_lsb: got %b expected 0000", {ready_a, valid_b, data_b, last_b});
        end
        n_checks++;
        if ({m_ready_a, m_valid_b, m_data_b, m_last_b} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_msb: got %b expected 0000", {m_ready_a, m_valid_b, m_data_b, m_last_b});
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (ready_a !== 1'b0) begin
            n_fail++; $display("FAIL ready_before_edge: got %b expected 0", ready_a);
        end
        @(negedge clk);
        n_checks++;
        if ({ready_a, valid_b, m_ready_a, m_valid_b} !== 4'b1010) begin
            n_fail++; $display("FAIL ready_after_release: got %b expected 1010", {ready_a, valid_b, m_ready_a, m_valid_b});
        end
    endtask

    task automatic test_single();
        logic [0:5] exp;
        exp = 6'b101101;
        @(negedge clk); valid_a = 1'b1; data_a = 6'b101101; ready_b = 1'b1;
        @(negedge clk); valid_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({valid_b, data_b, last_b} !== {1'b1, exp[i], (i == 5)}) begin
                n_fail++; $display("FAIL single bit %0d: got vdl=%b expected %b", i, {valid_b, data_b, last_b}, {1'b1, exp[i], (i == 5)});
            end
            @(negedge clk);
        end
        n_checks++;
        if ({valid_b, ready_a} !== 2'b01) begin
            n_fail++; $display("FAIL single_after: got valid/ready=%b expected 01", {valid_b, ready_a});
        end
    endtask

    task automatic test_back_to_back();
        logic [0:11] exp;
        exp = 12'b010101_101010;
        @(negedge clk); valid_a = 1'b1; data_a = 6'h2A; ready_b = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) data_a = 6'h15;
            else        valid_a = 1'b0;
            n_checks++;
            if ({valid_b, data_b, last_b} !== {1'b1, exp[i], (i == 5 || i == 11)}) begin
                n_fail++; $display("FAIL b2b bit %0d: got vdl=%b expected %b", i, {valid_b, data_b, last_b}, {1'b1, exp[i], (i == 5 || i == 11)});
            end
            n_checks++;
            if (ready_a !== ((i >= 1 && i <= 5) ? 1'b0 : 1'b1)) begin
                n_fail++; $display("FAIL b2b_ready cycle %0d: got %b expected %b", i, ready_a, (i >= 1 && i <= 5) ? 1'b0 : 1'b1);
            end
        end
        @(negedge clk);
        n_checks++;
        if (valid_b !== 1'b0) begin
            n_fail++; $display("FAIL b2b_after: got valid_b=%b expected 0", valid_b);
        end
    endtask

    task automatic test_stall();
        logic [0:5] exp;
        logic [0:3] pat;
        int k;
        exp = 6'b001111;
        pat = 4'b1001;
        k = 0;
        @(negedge clk); valid_a = 1'b1; data_a = 6'h3C; ready_b = 1'b0;
        @(negedge clk); valid_a = 1'b0;
        for (int c = 0; c < 12; c++) begin
            ready_b = pat[c % 4];
            n_checks++;
            if ({valid_b, data_b, last_b} !== {1'b1, exp[k], (k == 5)}) begin
                n_fail++; $display("FAIL stall cycle %0d bit %0d: got vdl=%b expected %b", c, k, {valid_b, data_b, last_b}, {1'b1, exp[k], (k == 5)});
            end
            if (ready_b) k++;
            @(negedge clk);
        end
        n_checks++;
        if (valid_b !== 1'b0) begin
            n_fail++; $display("FAIL stall_after: got valid_b=%b expected 0", valid_b);
        end
        ready_b = 1'b1;
    endtask

    task automatic test_edge_arrival();
        logic [0:11] exp;
        exp = 12'b111100_010010;
        @(negedge clk); valid_a = 1'b1; data_a = 6'h0F; ready_b = 1'b1;
        @(negedge clk); valid_a = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 5) begin valid_a = 1'b1; data_a = 6'h12; end
            else        valid_a = 1'b0;
            n_checks++;
            if ({valid_b, data_b, last_b, ready_a} !== {1'b1, exp[i], (i == 5 || i == 11), 1'b1}) begin
                n_fail++; $display("FAIL edge bit %0d: got vdlr=%b expected %b", i, {valid_b, data_b, last_b, ready_a}, {1'b1, exp[i], (i == 5 || i == 11), 1'b1});
            end
            @(negedge clk);
        end
        n_checks++;
        if (valid_b !== 1'b0) begin
            n_fail++; $display("FAIL edge_after: got valid_b=%b expected 0", valid_b);
        end
    endtask

    task automatic test_reset_mid();
        logic [0:5] exp;
        exp = 6'b100000;
        @(negedge clk); valid_a = 1'b1; data_a = 6'h3F; ready_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) data_a = 6'h2A;
            else        valid_a = 1'b0;
            n_checks++;
            if ({valid_b, data_b, last_b} !== 3'b110) begin
                n_fail++; $display("FAIL mid bit %0d: got vdl=%b expected 110", i, {valid_b, data_b, last_b});
            end
            if (i > 0) begin
                n_checks++;
                if (ready_a !== 1'b0) begin
                    n_fail++; $display("FAIL mid_hold_full cycle %0d: got ready_a=%b expected 0", i, ready_a);
                end
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ready_a, valid_b, data_b, last_b} !== 4'b0000) begin
            n_fail++; $display("FAIL mid_reset_async: got %b expected 0000", {ready_a, valid_b, data_b, last_b});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({ready_a, valid_b} !== 2'b10) begin
                n_fail++; $display("FAIL mid_discard cycle %0d: got ready/valid=%b expected 10", i, {ready_a, valid_b});
            end
        end
        valid_a = 1'b1; data_a = 6'h01;
        @(negedge clk); valid_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({valid_b, data_b, last_b} !== {1'b1, exp[i], (i == 5)}) begin
                n_fail++; $display("FAIL post_reset bit %0d: got vdl=%b expected %b", i, {valid_b, data_b, last_b}, {1'b1, exp[i], (i == 5)});
            end
            @(negedge clk);
        end
        n_checks++;
        if (valid_b !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_after: got valid_b=%b expected 0", valid_b);
        end
    endtask

    task automatic test_msb_first();
        logic [0:5] exp;
        exp = 6'b110000;
        @(negedge clk); m_valid_a = 1'b1; m_data_a = 6'b110000; m_ready_b = 1'b1;
        @(negedge clk); m_valid_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({m_valid_b, m_data_b, m_last_b} !== {1'b1, exp[i], (i == 5)}) begin
                n_fail++; $display("FAIL msb bit %0d: got vdl=%b expected %b", i, {m_valid_b, m_data_b, m_last_b}, {1'b1, exp[i], (i == 5)});
            end
            @(negedge clk);
        end
        n_checks++;
        if (m_valid_b !== 1'b0) begin
            n_fail++; $display("FAIL msb_after: got valid_b=%b expected 0", m_valid_b);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_edge_arrival();
        test_reset_mid();
        test_msb_first();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
